start_guard: RTL and testbench

Restart-loop guard and write arbiter in front of the start-table register.
- Counts consecutive system resets; after a configurable limit it disarms the start table, so a faulty start command cannot restart the system forever.
- Shares the start-table write port between itself and the CPU.
- Clears the reset count once the system has run stably for a fixed time.

---
 rtl/start_guard.sv | 115 +++++++++++
 tb/tb_start_guard.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/start_guard.sv
`default_nettype none
// ============================================================================
// Module      : start_guard
// Description : Restart-loop guard and write arbiter for the start-table port.
// Revision    : 1.0  initial release
// ============================================================================
module start_guard #(
  parameter int         STABLE_CYCLES = 25_000_000,
  parameter logic [3:0] LIMIT_DEF     = 4'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_start_wr,
  input  logic [15:0] cpu_start_data,
  input  logic        cfg_wr,
  input  logic [7:0]  cfg_data,
  output logic        start_wr,
  output logic [15:0] start_data,
  output logic [15:0] status
);

  localparam int              C_TW         = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [C_TW-1:0] C_TIMER_LAST = C_TW'(STABLE_CYCLES - 1);
  localparam logic [15:0]     C_DISARM_CMD = 16'h0004;

  localparam logic [1:0] S_CHECK  = 2'd0;
  localparam logic [1:0] S_DISARM = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_STABLE = 2'd3;

  // Configuration-time values only: these must survive rst_n so the guard
  // can count resets across them.
  logic [3:0] r_rst_cnt  = 4'd0;
  logic [3:0] r_limit    = LIMIT_DEF;
  logic       r_tripped  = 1'b0;
  logic       r_rst_prev = 1'b1;

  logic [1:0]      r_state;
  logic [C_TW-1:0] r_timer;
  logic            r_pend_v;
  logic [15:0]     r_pend_data;

  logic w_expire;
  logic w_disarm;

  assign w_expire = (r_state == S_RUN) && (r_timer == C_TIMER_LAST);
  assign w_disarm = (r_state == S_DISARM);

  always_ff @(posedge clk) begin
    r_rst_prev <= rst_n;
    if (!rst_n) begin
      if (r_rst_prev && (r_rst_cnt != 4'hF))
        r_rst_cnt <= r_rst_cnt + 4'd1;
    end else begin
      if (w_expire || (cfg_wr && cfg_data[4]))
        r_rst_cnt <= 4'd0;
      if (cfg_wr)
        r_limit <= cfg_data[3:0];
      // A guard trip in the same cycle as a clear leaves the flag set.
      if (w_disarm)
        r_tripped <= 1'b1;
      else if (cfg_wr && cfg_data[5])
        r_tripped <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_CHECK;
      r_timer     <= '0;
      r_pend_v    <= 1'b0;
      r_pend_data <= 16'h0000;
    end else begin
      case (r_state)
        S_CHECK:  r_state <= ((r_limit != 4'd0) && (r_rst_cnt >= r_limit)) ? S_DISARM : S_RUN;
        S_DISARM: r_state <= S_RUN;
        S_RUN: begin
          if (w_expire)
            r_state <= S_STABLE;
          else
            r_timer <= r_timer + C_TW'(1);
        end
        default:  r_state <= S_STABLE;
      endcase
      // A CPU write that collides with the guard, or arrives while one is
      // still queued, goes through the one-deep pend register in order.
      if (w_disarm || r_pend_v) begin
        r_pend_v <= cpu_start_wr;
        if (cpu_start_wr)
          r_pend_data <= cpu_start_data;
      end
    end
  end

  always_comb begin
    start_wr   = 1'b0;
    start_data = 16'h0000;
    if (rst_n) begin
      if (w_disarm) begin
        start_wr   = 1'b1;
        start_data = C_DISARM_CMD;
      end else if (r_pend_v) begin
        start_wr   = 1'b1;
        start_data = r_pend_data;
      end else if (cpu_start_wr) begin
        start_wr   = 1'b1;
        start_data = cpu_start_data;
      end
    end
  end

  assign status = {7'b0, r_tripped, r_limit, r_rst_cnt};

endmodule
`default_nettype wire

// File: tb/tb_start_guard.sv
`default_nettype none
// ============================================================================
// Module      : tb_start_guard
// Description : Directed self-checking bench for start_guard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_start_guard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_start_wr = 1'b0;
  logic [15:0] cpu_start_data = 16'h0000;
  logic        cfg_wr = 1'b0;
  logic [7:0]  cfg_data = 8'h00;
  logic        start_wr;
  logic [15:0] start_data;
  logic [15:0] status;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  logic [15:0] wr_last = 16'h0000;

  start_guard #(.STABLE_CYCLES(16), .LIMIT_DEF(4'd3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_start_wr   (cpu_start_wr),
    .cpu_start_data (cpu_start_data),
    .cfg_wr         (cfg_wr),
    .cfg_data       (cfg_data),
    .start_wr       (start_wr),
    .start_data     (start_data),
    .status         (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the falling edge and log any start-table write.
  task automatic step();
    @(negedge clk);
    #1;
    if (start_wr === 1'b1) begin
      wr_cnt++;
      wr_last = start_data;
    end
  endtask

  task automatic reset_pulse(input int low, input int high);
    rst_n = 1'b0;
    repeat (low) step();
    rst_n = 1'b1;
    repeat (high) step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("powerup_status", {16'h0, status}, 32'h0030);
    chk("powerup_wr", {31'h0, start_wr}, 32'h0);

    // Single reset pulse, then a full stable period clears the count.
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    chk("post_reset_status", {16'h0, status}, 32'h0031);
    chk("check_no_wr", {31'h0, start_wr}, 32'h0);
    repeat (16) step();
    chk("before_stable", {16'h0, status}, 32'h0031);
    step();
    chk("stable_cleared", {16'h0, status}, 32'h0030);

    // Idle CPU write forwarded combinationally.
    cpu_start_wr = 1'b1; cpu_start_data = 16'h0701;
    #1;
    chk("fwd_wr", {31'h0, start_wr}, 32'h1);
    chk("fwd_data", {16'h0, start_data}, 32'h0701);
    step();
    cpu_start_wr = 1'b0; cpu_start_data = 16'h0000;
    #1;
    chk("idle_data", {15'h0, start_wr, start_data}, 32'h0);

    // Three resets with limit 3: only the third trips the guard.
    wr_cnt = 0;
    reset_pulse(1, 5);
    chk("trip_r1_wr", wr_cnt, 0);
    reset_pulse(1, 5);
    chk("trip_r2_wr", wr_cnt, 0);
    reset_pulse(1, 5);
    chk("trip_r3_wr", wr_cnt, 1);
    chk("trip_data", {16'h0, wr_last}, 32'h0004);
    chk("trip_status", {16'h0, status}, 32'h0133);

    // CPU write colliding with the guard write is delayed, order preserved.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    cpu_start_wr = 1'b1; cpu_start_data = 16'h0501;
    #1;
    chk("coll_n", {15'h0, start_wr, start_data}, 32'h1_0004);
    step();
    cpu_start_data = 16'h0002;
    #1;
    chk("coll_n1", {15'h0, start_wr, start_data}, 32'h1_0501);
    step();
    cpu_start_wr = 1'b0; cpu_start_data = 16'h0000;
    #1;
    chk("coll_n2", {15'h0, start_wr, start_data}, 32'h1_0002);
    step();
    chk("coll_n3", {15'h0, start_wr, start_data}, 32'h0);
    chk("coll_status", {16'h0, status}, 32'h0134);

    // Config write clears count and trip; a long reset counts once.
    cfg_wr = 1'b1; cfg_data = 8'h33;
    step();
    cfg_wr = 1'b0; cfg_data = 8'h00;
    #1;
    chk("cfg33_status", {16'h0, status}, 32'h0030);
    wr_cnt = 0;
    reset_pulse(50, 3);
    chk("long_reset_status", {16'h0, status}, 32'h0031);
    chk("long_reset_wr", wr_cnt, 0);

    // Guard disabled: count climbs and saturates, no guard writes.
    cfg_wr = 1'b1; cfg_data = 8'h10;
    step();
    cfg_wr = 1'b0; cfg_data = 8'h00;
    #1;
    chk("cfg10_status", {16'h0, status}, 32'h0000);
    wr_cnt = 0;
    repeat (5) reset_pulse(1, 3);
    chk("dis5_status", {16'h0, status}, 32'h0005);
    chk("dis5_wr", wr_cnt, 0);
    repeat (12) reset_pulse(1, 3);
    chk("sat_status", {16'h0, status}, 32'h000F);
    chk("sat_wr", wr_cnt, 0);

    // During reset, config writes are ignored and CPU writes dropped.
    rst_n = 1'b0;
    cfg_wr = 1'b1; cfg_data = 8'h37;
    cpu_start_wr = 1'b1; cpu_start_data = 16'h0101;
    #1;
    chk("rst_cpu_drop", {15'h0, start_wr, start_data}, 32'h0);
    step();
    chk("rst_cfg_ignored", {16'h0, status}, 32'h000F);
    rst_n = 1'b1;
    cfg_wr = 1'b0; cfg_data = 8'h00;
    cpu_start_wr = 1'b0; cpu_start_data = 16'h0000;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
